// File: rtl/io_port_responder.sv
// io_port_responder: I/O strobe responder with an output byte FIFO that
// drains over a valid/ready handshake, and a single-byte input capture buffer
// with sticky overflow/overrun status.
// Optional build macro IO_PORT_IRQ_EN adds a masked, registered irq output.
module io_port_responder #(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       io_enable,
    input  logic       io_write_enable,
    input  logic       io_addr,
    input  logic [7:0] io_wdata,
    output logic [7:0] io_rdata,
    output logic       io_busy,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    input  logic [7:0] in_data,
`ifdef IO_PORT_IRQ_EN
    output logic       irq,
`endif
    input  logic       in_strobe
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } state_t;

    localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    // FIFO storage and bookkeeping
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    state_t           state_q, state_d;

    // Input side and status
    logic [7:0] in_buf_q;
    logic       in_full_q, in_full_d;
    logic       in_overrun_q, in_overrun_d;
    logic       out_overflow_q, out_overflow_d;
    logic [7:0] io_rdata_q, io_rdata_d;
    logic       irq_bit;

    // Access decode
    logic data_wr, ctrl_wr, data_rd, stat_rd;
    logic flush, pop, push, ovf_set, capture, overrun_set;

    assign data_wr = io_enable &  io_write_enable & ~io_addr;
    assign ctrl_wr = io_enable &  io_write_enable &  io_addr;
    assign data_rd = io_enable & ~io_write_enable & ~io_addr;
    assign stat_rd = io_enable & ~io_write_enable &  io_addr;

    assign flush   = ctrl_wr & io_wdata[0];
    // A flush wins over any handshake on the same cycle.
    assign pop     = out_valid & out_ready & ~flush;
    // A full FIFO still accepts a byte when its head leaves on the same edge.
    assign push    = data_wr & ((count_q != DEPTH_C) | pop);
    assign ovf_set = data_wr & ~push;

    // A full buffer takes a new byte only when the old one is read out together with it.
    assign capture     = in_strobe & (~in_full_q | data_rd);
    assign overrun_set = in_strobe & in_full_q & ~data_rd;

    assign out_valid = (state_q != ST_EMPTY);
    assign io_busy   = (state_q == ST_FULL);
    assign out_data  = mem_q[rd_ptr_q];
    assign io_rdata  = io_rdata_q;

    // FIFO storage, pointers and occupancy count
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            // Empty the queue by aligning the read pointer with the write pointer.
            rd_ptr_q <= wr_ptr_q;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= io_wdata;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (push && !pop)      count_q <= count_q + CNT_ONE;
            else if (pop && !push) count_q <= count_q - CNT_ONE;
        end
    end

    // FIFO occupancy state register
    always_ff @(posedge clk) begin
        if (!reset) state_q <= ST_EMPTY;
        else        state_q <= state_d;
    end

    // FIFO occupancy next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY:   if (push) state_d = ST_PARTIAL;
                ST_PARTIAL: begin
                    if (push && !pop && (count_q == DEPTH_C - CNT_ONE))
                        state_d = ST_FULL;
                    else if (pop && !push && (count_q == CNT_ONE))
                        state_d = ST_EMPTY;
                end
                ST_FULL:    if (pop && !push) state_d = ST_PARTIAL;
                default:    state_d = ST_EMPTY;
            endcase
        end
    end

    // Input buffer, sticky flags and read-data next values
    always_comb begin
        in_full_d = in_full_q;
        if (data_rd || (ctrl_wr && io_wdata[1])) in_full_d = 1'b0;
        if (capture) in_full_d = 1'b1;

        in_overrun_d   = overrun_set | (in_overrun_q & ~stat_rd);
        out_overflow_d = ovf_set | (out_overflow_q & ~stat_rd);

        io_rdata_d = io_rdata_q;
        if (data_rd)
            io_rdata_d = in_buf_q;
        else if (stat_rd)
            io_rdata_d = {3'b000, irq_bit, in_overrun_q, out_overflow_q, io_busy, in_full_q};
    end

    // Input buffer, sticky flags and read-data registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            in_buf_q       <= '0;
            in_full_q      <= 1'b0;
            in_overrun_q   <= 1'b0;
            out_overflow_q <= 1'b0;
            io_rdata_q     <= '0;
        end else begin
            if (capture) in_buf_q <= in_data;
            in_full_q      <= in_full_d;
            in_overrun_q   <= in_overrun_d;
            out_overflow_q <= out_overflow_d;
            io_rdata_q     <= io_rdata_d;
        end
    end

`ifdef IO_PORT_IRQ_EN
    logic irq_mask_q, irq_q;
    logic unused_wdata;
    assign unused_wdata = ^{io_wdata[7:6], io_wdata[3:2]};
    assign irq_bit      = irq_mask_q;
    assign irq          = irq_q;

    // Interrupt mask and registered, masked interrupt request
    always_ff @(posedge clk) begin
        if (!reset) begin
            irq_mask_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            if (ctrl_wr && io_wdata[4]) irq_mask_q <= io_wdata[5];
            irq_q <= ~irq_mask_q & (in_full_q | out_overflow_q | in_overrun_q);
        end
    end
`else
    logic unused_wdata;
    assign unused_wdata = ^io_wdata[7:2];
    assign irq_bit      = 1'b0;
`endif

endmodule

// File: tb/tb_io_port_responder.sv
// tb_io_port_responder: directed vector table for io_port_responder plus
// hand-written sequences for pointer wrap, flush and mid-transfer reset.
module tb_io_port_responder;

    logic       clk = 1'b0;
    logic       reset;
    logic       io_enable, io_write_enable, io_addr;
    logic [7:0] io_wdata;
    logic [7:0] io_rdata;
    logic       io_busy;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] in_data;
    logic       in_strobe;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    io_port_responder #(.FIFO_DEPTH(4), .PTR_W(2)) dut (
        .clk(clk),
        .reset(reset),
        .io_enable(io_enable),
        .io_write_enable(io_write_enable),
        .io_addr(io_addr),
        .io_wdata(io_wdata),
        .io_rdata(io_rdata),
        .io_busy(io_busy),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .in_data(in_data),
        .in_strobe(in_strobe)
    );

    typedef struct {
        logic       rst_n, en, we, a;
        logic [7:0] wd;
        logic       rdy;
        logic [7:0] sd;
        logic       st;
        logic [7:0] e_rd;
        logic       e_ov;
        logic [7:0] e_od;
        logic       e_bsy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst_n, en, we, a, input logic [7:0] wd,
                                input logic rdy, input logic [7:0] sd, input logic st,
                                input logic [7:0] e_rd, input logic e_ov,
                                input logic [7:0] e_od, input logic e_bsy);
        vec_t v;
        v.rst_n = rst_n; v.en = en; v.we = we; v.a = a; v.wd = wd;
        v.rdy = rdy; v.sd = sd; v.st = st;
        v.e_rd = e_rd; v.e_ov = e_ov; v.e_od = e_od; v.e_bsy = e_bsy;
        return v;
    endfunction

    task automatic drive(input logic rst_n, en, we, a, input logic [7:0] wd,
                         input logic rdy, input logic [7:0] sd, input logic st);
        reset = rst_n; io_enable = en; io_write_enable = we; io_addr = a;
        io_wdata = wd; out_ready = rdy; in_data = sd; in_strobe = st;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] rd, input logic ov,
                           input logic [7:0] od, input logic bsy);
        chk({tag, " io_rdata"},  io_rdata, rd);
        chk({tag, " out_valid"}, {7'b0, out_valid}, {7'b0, ov});
        chk({tag, " out_data"},  out_data, od);
        chk({tag, " io_busy"},   {7'b0, io_busy}, {7'b0, bsy});
    endtask

    initial begin
        // rst_n en we a  wd    rdy sd    st | rd    ov od    bsy
        vecs.push_back(mk(0,0,0,0,8'h00,0,8'h00,0, 8'h00,0,8'h00,0)); // 0 reset
        vecs.push_back(mk(1,1,1,0,8'h11,0,8'h00,0, 8'h00,1,8'h11,0)); // 1 OUT 11
        vecs.push_back(mk(1,1,1,0,8'h22,0,8'h00,0, 8'h00,1,8'h11,0)); // 2 OUT 22
        vecs.push_back(mk(1,0,0,0,8'h00,1,8'h00,0, 8'h00,1,8'h22,0)); // 3 pop 11
        vecs.push_back(mk(1,0,0,0,8'h00,1,8'h00,0, 8'h00,0,8'h00,0)); // 4 pop 22
        vecs.push_back(mk(1,0,0,0,8'h00,0,8'h00,0, 8'h00,0,8'h00,0)); // 5 idle
        vecs.push_back(mk(1,1,1,0,8'hA0,0,8'h00,0, 8'h00,1,8'hA0,0)); // 6
        vecs.push_back(mk(1,1,1,0,8'hA1,0,8'h00,0, 8'h00,1,8'hA0,0)); // 7
        vecs.push_back(mk(1,1,1,0,8'hA2,0,8'h00,0, 8'h00,1,8'hA0,0)); // 8
        vecs.push_back(mk(1,1,1,0,8'hA3,0,8'h00,0, 8'h00,1,8'hA0,1)); // 9 full
        vecs.push_back(mk(1,1,1,0,8'hA4,0,8'h00,0, 8'h00,1,8'hA0,1)); // 10 dropped
        vecs.push_back(mk(1,1,0,1,8'h00,0,8'h00,0, 8'h06,1,8'hA0,1)); // 11 status
        vecs.push_back(mk(1,1,0,1,8'h00,0,8'h00,0, 8'h02,1,8'hA0,1)); // 12 status
        vecs.push_back(mk(1,0,0,0,8'h00,1,8'h00,0, 8'h02,1,8'hA1,0)); // 13 drain
        vecs.push_back(mk(1,0,0,0,8'h00,1,8'h00,0, 8'h02,1,8'hA2,0)); // 14
        vecs.push_back(mk(1,0,0,0,8'h00,1,8'h00,0, 8'h02,1,8'hA3,0)); // 15
        vecs.push_back(mk(1,0,0,0,8'h00,1,8'h00,0, 8'h02,0,8'hA0,0)); // 16 empty
        vecs.push_back(mk(1,1,1,0,8'hB0,0,8'h00,0, 8'h02,1,8'hB0,0)); // 17
        vecs.push_back(mk(1,1,1,0,8'hB1,0,8'h00,0, 8'h02,1,8'hB0,0)); // 18
        vecs.push_back(mk(1,1,1,0,8'hB2,0,8'h00,0, 8'h02,1,8'hB0,0)); // 19
        vecs.push_back(mk(1,1,1,0,8'hB3,0,8'h00,0, 8'h02,1,8'hB0,1)); // 20 full
        vecs.push_back(mk(1,1,1,0,8'h55,1,8'h00,0, 8'h02,1,8'hB1,1)); // 21 push+pop
        vecs.push_back(mk(1,1,0,1,8'h00,0,8'h00,0, 8'h02,1,8'hB1,1)); // 22 no ovf
        vecs.push_back(mk(1,0,0,0,8'h00,1,8'h00,0, 8'h02,1,8'hB2,0)); // 23
        vecs.push_back(mk(1,0,0,0,8'h00,1,8'h00,0, 8'h02,1,8'hB3,0)); // 24
        vecs.push_back(mk(1,0,0,0,8'h00,1,8'h00,0, 8'h02,1,8'h55,0)); // 25
        vecs.push_back(mk(1,0,0,0,8'h00,1,8'h00,0, 8'h02,0,8'hB1,0)); // 26 empty
        vecs.push_back(mk(1,0,0,0,8'h00,0,8'h3C,1, 8'h02,0,8'hB1,0)); // 27 strobe
        vecs.push_back(mk(1,1,0,1,8'h00,0,8'h00,0, 8'h01,0,8'hB1,0)); // 28 status
        vecs.push_back(mk(1,1,0,0,8'h00,0,8'h00,0, 8'h3C,0,8'hB1,0)); // 29 data rd
        vecs.push_back(mk(1,1,0,1,8'h00,0,8'h00,0, 8'h00,0,8'hB1,0)); // 30 status
        vecs.push_back(mk(1,0,0,0,8'h00,0,8'h01,1, 8'h00,0,8'hB1,0)); // 31 strobe
        vecs.push_back(mk(1,0,0,0,8'h00,0,8'h02,1, 8'h00,0,8'hB1,0)); // 32 overrun
        vecs.push_back(mk(1,1,0,1,8'h00,0,8'h00,0, 8'h09,0,8'hB1,0)); // 33 status
        vecs.push_back(mk(1,1,0,0,8'h00,0,8'h00,0, 8'h01,0,8'hB1,0)); // 34 data rd
        vecs.push_back(mk(1,1,0,1,8'h00,0,8'h00,0, 8'h00,0,8'hB1,0)); // 35 status
        vecs.push_back(mk(1,0,0,0,8'h00,0,8'h77,1, 8'h00,0,8'hB1,0)); // 36 strobe
        vecs.push_back(mk(1,1,0,0,8'h00,0,8'h88,1, 8'h77,0,8'hB1,0)); // 37 rd+strobe
        vecs.push_back(mk(1,1,0,1,8'h00,0,8'h00,0, 8'h01,0,8'hB1,0)); // 38 no overrun
        vecs.push_back(mk(1,1,0,0,8'h00,0,8'h00,0, 8'h88,0,8'hB1,0)); // 39 data rd
        vecs.push_back(mk(1,0,0,0,8'h00,0,8'h99,1, 8'h88,0,8'hB1,0)); // 40 strobe
        vecs.push_back(mk(1,1,1,1,8'h02,0,8'h00,0, 8'h88,0,8'hB1,0)); // 41 clr in_full
        vecs.push_back(mk(1,1,0,1,8'h00,0,8'h00,0, 8'h00,0,8'hB1,0)); // 42 status

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].en, vecs[i].we, vecs[i].a, vecs[i].wd,
                  vecs[i].rdy, vecs[i].sd, vecs[i].st);
            chk_all($sformatf("vec%0d", i), vecs[i].e_rd, vecs[i].e_ov,
                    vecs[i].e_od, vecs[i].e_bsy);
        end

        // Pointer wrap: back-to-back push/pop keeps at most one byte queued.
        for (int k = 0; k < 10; k++) begin
            drive(1, 1, 1, 0, 8'(k), 1, 8'h00, 0);
            chk_all($sformatf("wrap%0d", k), 8'h00, 1'b1, 8'(k), 1'b0);
        end
        drive(1, 0, 0, 0, 8'h00, 1, 8'h00, 0);
        chk({"wrap_end out_valid"}, {7'b0, out_valid}, 8'h00);

        // Flush with a queue of three bytes; same-cycle pop is ignored.
        drive(1, 1, 1, 0, 8'hD0, 0, 8'h00, 0);
        drive(1, 1, 1, 0, 8'hD1, 0, 8'h00, 0);
        drive(1, 1, 1, 0, 8'hD2, 0, 8'h00, 0);
        chk_all("preflush", 8'h00, 1'b1, 8'hD0, 1'b0);
        drive(1, 1, 1, 1, 8'h01, 1, 8'h00, 0);
        chk({"flush out_valid"}, {7'b0, out_valid}, 8'h00);
        chk({"flush io_busy"}, {7'b0, io_busy}, 8'h00);
        drive(1, 1, 1, 0, 8'hC0, 0, 8'h00, 0);
        chk_all("postflush", 8'h00, 1'b1, 8'hC0, 1'b0);

        // Reset while three bytes are queued and the input buffer is full.
        drive(1, 1, 1, 0, 8'hC1, 0, 8'h00, 0);
        drive(1, 1, 1, 0, 8'hC2, 0, 8'h5A, 1);
        drive(1, 1, 0, 0, 8'h00, 0, 8'h00, 0);
        chk("rd 5A", io_rdata, 8'h5A);
        drive(1, 0, 0, 0, 8'h00, 0, 8'h6B, 1);
        chk_all("prereset", 8'h5A, 1'b1, 8'hC0, 1'b0);
        drive(0, 0, 0, 0, 8'h00, 0, 8'h00, 0);
        chk_all("midreset", 8'h00, 1'b0, 8'h00, 1'b0);
        drive(1, 1, 0, 1, 8'h00, 0, 8'h00, 0);
        chk("postreset status", io_rdata, 8'h00);
        drive(1, 1, 0, 0, 8'h00, 0, 8'h00, 0);
        chk("postreset in_buf", io_rdata, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/io_port_responder.md
Name: io_port_responder

Overview:
- Memory-less I/O responder on the CPU I/O strobe interface: io_enable, io_write_enable, and byte data from the data register.
- Sits between the control unit / data register and the external pins.
- OUT writes go into an output FIFO that drains to the pins through a valid/ready handshake.
- IN reads return a byte captured from the input pins, or a status byte.

Parameters:
- FIFO_DEPTH, 4: output FIFO entries; power of two, 2..16.
- PTR_W, 2: log2(FIFO_DEPTH).

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-low reset; sampled on rising clk
- io_enable  input  1  I/O cycle strobe; one cycle per access
- io_write_enable  input  1  1 = write (OUT), 0 = read (IN); valid when io_enable=1
- io_addr  input  1  0 = data port, 1 = status/control
- io_wdata  input  8  write data from data register
- io_rdata  output  8  read data, registered
- io_busy  output  1  output FIFO full (count==FIFO_DEPTH)
- out_data  output  8  FIFO head byte
- out_valid  output  1  FIFO not empty
- out_ready  input  1  pin side accepts out_data when out_valid&out_ready
- in_data  input  8  pin-side input byte
- in_strobe  input  1  capture in_data this cycle

Behaviour:
- Reset (reset==0 at an edge):
  - FIFO empty, pointers and count 0.
  - io_rdata=8'h00, out_valid=0, out_data=8'h00, io_busy=0.
  - in_buf=8'h00, in_full=0, sticky flags 0.
  - Reset mid-transfer discards all queued data.
- Write, addr 0:
  - Push io_wdata if count<FIFO_DEPTH, or if count==FIFO_DEPTH and a pop occurs the same cycle.
  - Otherwise the byte is dropped and sticky out_overflow is set.
- Write, addr 1:
  - io_wdata[0]=1 flushes the FIFO (count=0) the next cycle; any same-cycle pop is ignored.
  - io_wdata[1]=1 clears in_full.
  - Other bits ignored.
- Pop: when out_valid&out_ready. Pointers wrap modulo FIFO_DEPTH. out_data is always mem[rd_ptr]; it shows the new head the cycle after a pop.
- Count update: +1 on push only, -1 on pop only, unchanged on push+pop.
- Read, addr 0:
  - io_rdata <= in_buf on the next edge (latency 1). Held until the next read.
  - Clears in_full.
- Read, addr 1:
  - io_rdata <= {4'b0, in_overrun, out_overflow, io_busy, in_full}.
  - Clears in_overrun and out_overflow; a same-cycle set wins over the clear.
- io_rdata is unchanged on cycles without a read.
- Input capture:
  - in_strobe with in_full=0: in_buf<=in_data, in_full<=1.
  - in_strobe with in_full=1 and no same-cycle data read: byte dropped, in_overrun<=1.
  - in_strobe plus a same-cycle data read while full: io_rdata gets the old byte, in_buf gets the new byte, in_full stays 1, no overrun.
- io_enable=0: io_write_enable, io_addr and io_wdata are don't-care.
- FSM per FIFO: EMPTY (count 0), PARTIAL, FULL; out_valid = state!=EMPTY, io_busy = state==FULL.
  - EMPTY -> PARTIAL on push.
  - PARTIAL -> FULL on push-only reaching FIFO_DEPTH.
  - PARTIAL -> EMPTY on pop-only reaching 0.
  - FULL -> PARTIAL on pop-only.
  - Any state -> EMPTY on flush.

Optional Feature:
- Macro IO_PORT_IRQ_EN.
- Defined: adds output irq (1 bit, registered, reset 0) = in_full | out_overflow | in_overrun, updated every cycle. Status bit 4 reads irq_mask; a control write with io_wdata[4] sets irq_mask=io_wdata[5], and irq is forced 0 while irq_mask=1.
- Undefined: no irq port and no irq_mask; status bit 4 reads 0.

Test Plan:
- Reset, then OUT writes 8'h11, 8'h22 with out_ready=0 -> out_valid=1, out_data=8'h11, io_busy=0. Raise out_ready -> 8'h11, then 8'h22 accepted on consecutive edges, then out_valid=0.
- 5 writes 8'hA0..8'hA4 with out_ready=0 (depth 4) -> io_busy=1 after the 4th. 8'hA4 dropped; status read returns 8'h06 (overflow|busy), a second status read returns 8'h02. Drain yields A0..A3 in order.
- Full FIFO, write 8'h55 in the same cycle as a pop -> count stays 4, 8'h55 is the last byte out, no overflow.
- in_strobe in_data=8'h3C -> status=8'h01. Data read -> io_rdata=8'h3C next cycle, in_full=0. Two strobes 8'h01, 8'h02 without a read -> in_buf=8'h01, in_overrun=1.
- Pointer wrap: 10 push/pop pairs of 8'h00..8'h09 with out_ready=1 -> same order out, count never exceeds 1. Control write 8'h01 mid-queue -> out_valid=0 next cycle.
- Assert reset for one edge while FIFO holds 3 bytes and in_full=1 -> all outputs return to reset values on that edge.
